// File: rtl/pwm_multi.sv
// N-channel PWM with one shared counter and double-buffered period/duty.
// Define PWM_CENTER_EN for a centre-aligned (triangle) counter.
module pwm_multi #(
    parameter int clk_mhz   = 50,
    parameter int freq_khz  = 400,
    parameter int duty      = 40,
    parameter int channels  = 4,
    parameter int cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 period_we,
    input  logic                 duty_we,
    input  logic [(channels > 1 ? $clog2(channels) : 1)-1:0] cfg_sel,
    input  logic [cnt_width-1:0] cfg_period,
    input  logic [cnt_width-1:0] cfg_duty,
    output logic [channels-1:0]  out,
    output logic                 period_end,
    output logic                 pending
);
    localparam int P0 = (2000 * clk_mhz + freq_khz) / (2 * freq_khz);
    localparam int D0 = (2 * duty * P0 + 100) / 200;
    localparam logic [cnt_width-1:0] P0W  = cnt_width'(P0);
    localparam logic [cnt_width-1:0] D0W  = cnt_width'(D0);
    localparam logic [cnt_width-1:0] ONE  = cnt_width'(1);
    localparam logic [cnt_width-1:0] ZERO = '0;

    logic [cnt_width-1:0] cnt_q, cnt_d;
    logic [cnt_width-1:0] per_q, per_d;
    logic [cnt_width-1:0] per_sh_q, per_sh_d;
    logic [cnt_width-1:0] duty_q [channels];
    logic [cnt_width-1:0] duty_d [channels];
    logic [cnt_width-1:0] duty_sh_q [channels];
    logic [cnt_width-1:0] duty_sh_d [channels];
    logic                 pending_q, pending_d;
    logic [cnt_width-1:0] pe, pe_m1;
    logic                 sel_ok, term, xfer;

`ifdef PWM_CENTER_EN
    typedef enum logic {UP, DOWN} dir_e;
    dir_e dir_q, dir_d;
`endif

    assign sel_ok = 32'(cfg_sel) < channels;
    assign pe     = (per_q == ZERO) ? ONE : per_q;
    assign pe_m1  = pe - ONE;

`ifdef PWM_CENTER_EN
    assign term = en && dir_q == DOWN && cnt_q == ZERO;
`else
    assign term = en && cnt_q == pe_m1;
`endif
    // Disabled counter behaves as a permanent boundary: shadows flow through.
    assign xfer = !en || term;

    always_comb begin
        per_sh_d  = per_sh_q;
        duty_sh_d = duty_sh_q;
        if (period_we)
            per_sh_d = cfg_period;
        if (duty_we && sel_ok)
            duty_sh_d[cfg_sel] = cfg_duty;
        per_d     = xfer ? per_sh_d : per_q;
        duty_d    = xfer ? duty_sh_d : duty_q;
        pending_d = xfer ? 1'b0
                  : pending_q | period_we | (duty_we & sel_ok);
`ifdef PWM_CENTER_EN
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (!en) begin
            cnt_d = ZERO;
            dir_d = UP;
        end else if (dir_q == UP) begin
            if (cnt_q == pe_m1)
                dir_d = DOWN;
            else
                cnt_d = cnt_q + ONE;
        end else if (term) begin
            dir_d = UP;
        end else begin
            cnt_d = cnt_q - ONE;
        end
`else
        cnt_d = xfer ? ZERO : cnt_q + ONE;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= ZERO;
            per_q     <= P0W;
            per_sh_q  <= P0W;
            pending_q <= 1'b0;
            for (int i = 0; i < channels; i++) begin
                duty_q[i]    <= D0W;
                duty_sh_q[i] <= D0W;
            end
        end else begin
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            per_sh_q  <= per_sh_d;
            pending_q <= pending_d;
            duty_q    <= duty_d;
            duty_sh_q <= duty_sh_d;
        end
    end

`ifdef PWM_CENTER_EN
    always_ff @(posedge clk) begin
        if (rst)
            dir_q <= UP;
        else
            dir_q <= dir_d;
    end
`endif

    always_comb begin
        out = '0;
        for (int i = 0; i < channels; i++)
            out[i] = en && (cnt_q < duty_q[i]);
    end

    assign period_end = term;
    assign pending    = pending_q;
endmodule
